// File: rtl/burst_ram_pkg.sv
// Shared definitions for the BurstRAM responder: command encodings and FSM states.
package burst_ram_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_BURST,
    ST_WRITE_BURST
  } state_t;

endpackage

// File: rtl/burst_ram_array.sv
// Single-port word array: synchronous write with per-byte enables, registered read.
// Contents are not cleared by reset; only the read register is.
module burst_ram_array #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic                         we,
  input  logic [DATA_BITWIDTH/8-1:0]   byte_en,
  input  logic [DATA_BITWIDTH-1:0]     wdata,
  input  logic                         re,
  output logic [DATA_BITWIDTH-1:0]     rdata
);

  localparam int unsigned NUM_BYTES = DATA_BITWIDTH / 8;

  logic [DATA_BITWIDTH-1:0] mem [0:(2**DEPTH_BITWIDTH)-1];

  // Byte-masked write of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (byte_en[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Responder end of the BurstRAM interface. Accepts read/write burst commands
// and serves them from an internal word array, modelling init delay, read
// latency and burst beats. Image preload (DATA_FILE) is left to the target flow.
module burst_ram_responder
  import burst_ram_pkg::*;
#(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned INIT_CYCLES    = 8,
  parameter              DATA_FILE      = ""
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd,
  input  logic                         cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH-1:0]     wr_data,
  input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
  output logic [DATA_BITWIDTH-1:0]     rd_data,
  output logic                         rd_data_valid,
  output logic                         busy
);

  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int unsigned BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_COUNT - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  state_t                      state, state_nxt;
  logic [DEPTH_BITWIDTH-1:0]   addr_q;
  logic [LAT_W-1:0]            lat_cnt;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [INIT_W-1:0]           init_cnt;

  logic                        lat_done, beat_last, init_done;
  logic [DEPTH_BITWIDTH-1:0]   mem_addr;
  logic                        mem_we, mem_re;
  logic [DATA_BITWIDTH/8-1:0]  mem_byte_en;

  assign lat_done  = (lat_cnt == LAT_LAST);
  assign beat_last = (beat_cnt == BEAT_LAST);
  assign init_done = (init_cnt == INIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:        if (init_done) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (cmd_en) begin
          if (cmd == CMD_WRITE) state_nxt = (BURST_COUNT > 1) ? ST_WRITE_BURST : ST_IDLE;
          else                  state_nxt = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT:   if (lat_done)  state_nxt = ST_READ_BURST;
      ST_READ_BURST:  if (beat_last) state_nxt = ST_IDLE;
      ST_WRITE_BURST: if (beat_last) state_nxt = ST_IDLE;
      default:        state_nxt = ST_INIT;
    endcase
  end

  // Init, latency and beat counters plus the latched burst base address
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      init_cnt <= '0;
    end else begin
      unique case (state)
        ST_INIT: if (!init_done) init_cnt <= init_cnt + INIT_W'(1);
        ST_IDLE: begin
          if (cmd_en) begin
            addr_q   <= addr;
            lat_cnt  <= '0;
            // write beat 0 is consumed at acceptance, so the burst resumes at beat 1
            beat_cnt <= (cmd == CMD_WRITE) ? BEAT_W'(1) : '0;
          end
        end
        ST_READ_WAIT:                  lat_cnt  <= lat_cnt + LAT_W'(1);
        ST_READ_BURST, ST_WRITE_BURST: beat_cnt <= beat_cnt + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs and array control; the array read register is loaded one edge
  // ahead so each beat's data appears in the same cycle as rd_data_valid
  always_comb begin
    busy          = (state != ST_IDLE);
    rd_data_valid = (state == ST_READ_BURST);
    mem_addr      = addr_q;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_byte_en   = ~data_mask;
    unique case (state)
      ST_IDLE: begin
        mem_addr = addr;
        mem_we   = cmd_en & (cmd == CMD_WRITE) & ~rst;
      end
      ST_READ_WAIT:   mem_re = lat_done;
      ST_READ_BURST: begin
        mem_addr = addr_q + DEPTH_BITWIDTH'(beat_cnt) + DEPTH_BITWIDTH'(1);
        mem_re   = ~beat_last;
      end
      ST_WRITE_BURST: begin
        mem_addr = addr_q + DEPTH_BITWIDTH'(beat_cnt);
        mem_we   = ~rst;
      end
      default: ;
    endcase
  end

  burst_ram_array #(
    .DEPTH_BITWIDTH (DEPTH_BITWIDTH),
    .DATA_BITWIDTH  (DATA_BITWIDTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .addr    (mem_addr),
    .we      (mem_we),
    .byte_en (mem_byte_en),
    .wdata   (wr_data),
    .re      (mem_re),
    .rdata   (rd_data)
  );

endmodule
